// File: rtl/stream_pool2d.sv
// Streaming 2x2 stride-2 pooling with a half-width line buffer.
// Define POOL_AVG_EN to compile in average pooling (pool_mode=1); otherwise max only.
module stream_pool2d #(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned IMG_W  = 30,
    parameter int unsigned IMG_H  = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pool_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned XW     = $clog2(IMG_W);
    localparam int unsigned YW     = $clog2(IMG_H);
    localparam int unsigned LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
`ifdef POOL_AVG_EN
    localparam int unsigned PW     = DATA_W + 1;
`else
    localparam int unsigned PW     = DATA_W;
`endif
    localparam int unsigned SW     = DATA_W + 2;

    localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                    state_q, state_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic                      mode_q;
    logic signed [DATA_W-1:0]  h_q;
    logic signed [PW-1:0]      lbuf_q [HALF_W];
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;

    logic                      accept;
    logic                      last_pix;
    logic                      load;
    logic [LW-1:0]             lidx;
    logic signed [PW-1:0]      h_ext, in_ext, pair_max, pair, lb_rd;
    logic signed [DATA_W-1:0]  res_max, res;

    assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_pix = (x_q == XLast) && (y_q == YLast);
    assign load     = accept && x_q[0] && y_q[0];
    assign lidx     = LW'(x_q >> 1);

    assign h_ext    = PW'(h_q);
    assign in_ext   = PW'(in_data);
    assign pair_max = (h_ext > in_ext) ? h_ext : in_ext;
    assign lb_rd    = lbuf_q[lidx];
    assign res_max  = DATA_W'((pair > lb_rd) ? pair : lb_rd);

`ifdef POOL_AVG_EN
    logic signed [SW-1:0] sum4;

    // Pair sums keep one guard bit; the 4-way sum needs two before the floor shift.
    assign pair = mode_q ? (h_ext + in_ext) : pair_max;
    assign sum4 = SW'(pair) + SW'(lb_rd);
    assign res  = mode_q ? DATA_W'(sum4 >>> 2) : res_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            mode_q <= pool_mode;
        end
    end
`else
    logic unused_mode;

    assign mode_q      = 1'b0;
    assign unused_mode = pool_mode ^ mode_q;
    assign pair        = pair_max;
    assign res         = res_max;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    if (x_q == XLast) begin
                        x_d = '0;
                        y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_pix) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A new result only loads when in_ready, i.e. the old one is gone or leaving.
    always_comb begin
        out_valid_d = load | (out_valid_q & ~out_ready);
        out_data_d  = load ? res : out_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // No reset on the pixel hold and line buffer so they map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (accept && !x_q[0]) begin
            h_q <= in_data;
        end
        if (accept && x_q[0] && !y_q[0]) begin
            lbuf_q[lidx] <= pair;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == StRun) || (state_q == StFlush);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_stream_pool2d.sv
// Self-checking bench for stream_pool2d: a 4x4 and a 30x30 instance behind a shared
// stimulus mux, with a scoreboard of expected pooled results.
module tb_stream_pool2d;

    localparam int DW = 22;
`ifdef POOL_AVG_EN
    localparam bit AvgEn = 1'b1;
`else
    localparam bit AvgEn = 1'b0;
`endif
    localparam logic signed [DW-1:0] MaxP = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MinP = {1'b1, {(DW-1){1'b0}}};

    logic clk = 1'b0;
    logic rst, start, pool_mode, in_valid, out_ready, sel;
    logic signed [DW-1:0] in_data;

    logic s_in_ready, s_out_valid, s_busy, s_done;
    logic l_in_ready, l_out_valid, l_busy, l_done;
    logic signed [DW-1:0] s_out_data, l_out_data;
    logic in_ready, out_valid, busy, done;
    logic signed [DW-1:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int ready_mode = 0;  // 0: always ready, 1: 3 low cycles per beat, 2: held low
    logic signed [DW-1:0] sb [$];
    logic signed [DW-1:0] frame [900];

    always #5 clk = ~clk;

    stream_pool2d #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_small (
        .clk(clk), .rst(rst), .start(start & ~sel), .pool_mode(pool_mode),
        .in_valid(in_valid & ~sel), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .busy(s_busy), .done(s_done)
    );

    stream_pool2d #(.DATA_W(DW), .IMG_W(30), .IMG_H(30)) u_large (
        .clk(clk), .rst(rst), .start(start & sel), .pool_mode(pool_mode),
        .in_valid(in_valid & sel), .in_ready(l_in_ready), .in_data(in_data),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
        .busy(l_busy), .done(l_done)
    );

    assign in_ready  = sel ? l_in_ready  : s_in_ready;
    assign out_valid = sel ? l_out_valid : s_out_valid;
    assign out_data  = sel ? l_out_data  : s_out_data;
    assign busy      = sel ? l_busy      : s_busy;
    assign done      = sel ? l_done      : s_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic set_win(input int w, input int wx, input int wy,
                           input int a, input int b, input int c, input int d);
        frame[(2*wy)*w + 2*wx]       = DW'(a);
        frame[(2*wy)*w + 2*wx + 1]   = DW'(b);
        frame[(2*wy+1)*w + 2*wx]     = DW'(c);
        frame[(2*wy+1)*w + 2*wx + 1] = DW'(d);
    endtask

    task automatic fill_random(input int n, input bit neg_only);
        for (int i = 0; i < n; i++) begin
            frame[i] = DW'($urandom);
            if (neg_only) frame[i][DW-1] = 1'b1;
        end
    endtask

    task automatic push_model(input int w, input int h, input bit avg);
        for (int wy = 0; wy < h/2; wy++) begin
            for (int wx = 0; wx < w/2; wx++) begin
                longint a, b, c, d, s;
                a = frame[(2*wy)*w + 2*wx];
                b = frame[(2*wy)*w + 2*wx + 1];
                c = frame[(2*wy+1)*w + 2*wx];
                d = frame[(2*wy+1)*w + 2*wx + 1];
                if (avg) begin
                    s = (a + b + c + d) >>> 2;
                end else begin
                    s = a;
                    if (b > s) s = b;
                    if (c > s) s = c;
                    if (d > s) s = d;
                end
                sb.push_back(DW'(s));
            end
        end
    endtask

    task automatic send_pix(input logic signed [DW-1:0] d, input bit st);
        int guard;
        in_data  = d;
        in_valid = 1'b1;
        start    = st;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("accept_timeout", guard, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic start_frame(input bit big, input bit mode);
        sel       = big;
        pool_mode = mode;
        done_cnt  = 0;
        beat_cnt  = 0;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        chk("busy_run", busy, 1);
    endtask

    task automatic run_frame(input bit big, input bit mode, input bit gaps, input bit stall,
                             input int start_at, input bit hold_last);
        int w, n, guard;
        w = big ? 30 : 4;
        n = w * w;
        ready_mode = stall ? 1 : 0;
        start_frame(big, mode);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (hold_last && i == n - 1) begin
                ready_mode = 2;
                @(posedge clk); #1;
            end
            send_pix(frame[i], i == start_at);
        end
        if (hold_last) begin
            repeat (4) @(negedge clk);
            chk("flush_busy", busy, 1);
            chk("flush_valid", out_valid, 1);
            chk("flush_no_done", done, 0);
            @(posedge clk); #1;
            ready_mode = 0;
        end
        guard = 0;
        @(negedge clk);
        while (!done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("done_count", done_cnt, 1);
        chk("beats", beat_cnt, n / 4);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Downstream ready pattern.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if (ready_mode == 2) begin
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (stall_cnt == 3) begin
                    out_ready = 1'b1;
                    stall_cnt = 0;
                end else begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end
            end else begin
                out_ready = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Output monitor: scoreboard pop, stall stability, backpressure, done count.
    initial begin
        bit prev_stall;
        logic signed [DW-1:0] prev_data, exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_valid && out_ready) begin
                    beat_cnt++;
                    chk("sb_underflow", sb.size() == 0, 0);
                    if (sb.size() > 0) begin
                        exp = sb.pop_front();
                        chk("out_data", out_data, exp);
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, prev_data);
                end
                if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
                if (done) done_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; pool_mode = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 0..15 raster, max: 5, 7, 13, 15
        for (int i = 0; i < 16; i++) frame[i] = DW'(i);
        sb.push_back(DW'(5)); sb.push_back(DW'(7));
        sb.push_back(DW'(13)); sb.push_back(DW'(15));
        run_frame(0, 0, 0, 0, -1, 0);

        // All-negative window in the top-left, max -> -1
        fill_random(16, 1);
        set_win(4, 0, 0, -3, -1, -8, -2);
        push_model(4, 4, 0);
        run_frame(0, 0, 0, 0, -1, 0);

        // Average corner cases (falls back to max when average is not compiled in)
        set_win(4, 0, 0, -1, -1, -1, -2);
        set_win(4, 1, 0, 1, 2, 3, 5);
        set_win(4, 0, 1, MaxP, MaxP, MaxP, MaxP);
        set_win(4, 1, 1, MinP, MinP, MinP, MinP);
        sb.push_back(AvgEn ? DW'(-2) : DW'(-1));
        sb.push_back(AvgEn ? DW'(2) : DW'(5));
        sb.push_back(MaxP);
        sb.push_back(MinP);
        run_frame(0, 1, 0, 0, -1, 0);

        // start during RUN is ignored; last result held in FLUSH
        fill_random(16, 0);
        push_model(4, 4, 0);
        run_frame(0, 0, 0, 0, 5, 1);

        // Full-size frame with input gaps and output stalls
        fill_random(900, 0);
        push_model(30, 30, AvgEn);
        run_frame(1, 1, 1, 1, -1, 0);

        // Reset after 100 pixels, then a fresh full frame
        fill_random(900, 0);
        push_model(30, 30, 0);
        ready_mode = 0;
        start_frame(1, 0);
        for (int i = 0; i < 100; i++) send_pix(frame[i], 1'b0);
        rst = 1'b0;
        sb.delete();
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_no_done", done_cnt, 0);
        @(posedge clk); #1;
        fill_random(900, 0);
        push_model(30, 30, 0);
        run_frame(1, 0, 0, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_pool2d.md
Name: stream_pool2d

Overview:
Streaming 2x2, stride-2 pooling stage for the CNN datapath, following the convolution output. Consumes a raster-order feature map with a valid/ready handshake and emits a (IMG_W/2)x(IMG_H/2) map with a valid/ready handshake. Uses a half-width line buffer instead of a full frame buffer. Max pooling is always available; average pooling is available when compiled in.

Parameters:
DATA_W, 22, signed pixel width in and out
IMG_W, 30, input map width; must be even, at least 2
IMG_H, 30, input map height; must be even, at least 2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse; honoured only in IDLE
pool_mode  in  1  0 = max, 1 = average; sampled at an accepted start
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
in_data  in  DATA_W  signed input pixel, raster order
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accepts the result
out_data  out  DATA_W  signed pooled result
busy  out  1  high in RUN and FLUSH
done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Counters, mode register and state are cleared. Line buffer contents are don't-care.
- States are IDLE, RUN, FLUSH, DONE.
- IDLE to RUN: on start. Clear x/y counters and latch pool_mode into mode_q.
- RUN to FLUSH: on the cycle the pixel at (IMG_W-1, IMG_H-1) is accepted.
- FLUSH to DONE: when out_valid=0, or when out_valid and out_ready are both high.
- DONE to IDLE: unconditionally. done=1 only while in DONE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) and (!out_valid or out_ready). A pixel is accepted when in_valid and in_ready are both high.
- Horizontal pair:
  - At even x, hold the pixel in h_reg.
  - At odd x, form pair = max(h_reg, in_data) in max mode, or h_reg + in_data (DATA_W+1 bits, sign-extended) in average mode.
- Even row: write pair into lbuf[x/2]. No output is produced.
- Odd row, at odd x, combine pair with lbuf[x/2]:
  - Max mode: result = max of the two.
  - Average mode: sum the two at DATA_W+2 bits, then arithmetic shift right by 2 (floor toward minus infinity), then truncate to DATA_W.
  - Register the result into out_data and set out_valid on the next clock edge. Latency is 1 cycle after the bottom-right pixel of the window is accepted.
- out_valid holds, and out_data stays stable, until out_ready is high. Clear out_valid when out_ready is high and no new result is loaded that cycle.
- Back-to-back results are loaded in the same cycle the previous one is accepted, so there is no bubble.
- Comparisons are signed. On a tie, either operand may be output since the values are identical.
- x wraps to 0 after IMG_W-1 and y increments. y wraps to 0 after IMG_H-1.
- Total outputs per frame: (IMG_W/2)*(IMG_H/2), which is 225 at the defaults.
- The lbuf depth is IMG_W/2 and its width is DATA_W+1. It is inferable as distributed RAM.
- Reset in mid-frame discards everything and returns to IDLE. A partial frame produces no done.
- in_valid is ignored outside RUN.

Optional Feature:
Macro POOL_AVG_EN.
- Defined: average mode as described above; lbuf and pair paths are DATA_W+1 bits wide.
- Not defined: pool_mode is ignored and mode_q is tied to 0, giving max only. lbuf and pair paths are DATA_W bits wide and no adder logic is present. Port list is unchanged.

Test Plan:
- 4x4 map (IMG_W=IMG_H=4), values 0..15 in raster order, max mode, out_ready=1 -> outputs 5, 7, 13, 15 in order; done pulses once; exactly 4 out_valid beats.
- 2x2 map of all negatives {-3,-1,-8,-2}, max mode -> single output -1.
- POOL_AVG_EN, 2x2 maps:
  - {-1,-1,-1,-2} -> -2 (floor of -5/4).
  - {1,2,3,5} -> 2.
  - {2^(DATA_W-1)-1} x4 -> 2^(DATA_W-1)-1, with no overflow.
- Default 30x30 map, random in_valid gaps and out_ready held low 3 cycles per beat -> 225 results matching a golden model; out_data stable while stalled; in_ready low whenever out_valid=1 and out_ready=0.
- Reset asserted after 100 pixels, then start and a full frame -> first output is correct for the new frame; no stale lbuf data; done pulses once.
- start pulsed during RUN -> ignored, counters undisturbed. Frame ends with the last output held in FLUSH until out_ready rises, then done is a single-cycle pulse.
